b4sq_credit_tracker: RTL and testbench

B4SQ_CREDIT_TRACKER -- requirements
Module: b4sq_credit_tracker

---
 rtl/b4sq_credit_tracker.sv | 191 +++++++++++++++++++
 tb/tb_b4sq_credit_tracker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b4sq_credit_tracker.sv
// rtl/b4sq_credit_tracker.sv - transmit flow-control credit tracker for P/NP/CPL classes
// Ports:
//   i_clk, i_rst_n              clock; asynchronous active-low reset, released on a clock edge
//   i_dl_up                     data-link-up level; low returns the tracker to LINK_DOWN
//   i_fc_init_*                 InitFC from the link partner (type 0=P, 1=NP, 2=CPL)
//   i_fc_upd_*                  UpdateFC from the link partner (same type encoding)
//   i_tx_req/type/dat_cred      transmit request, its class and the data credits it needs
//   o_tx_gnt                    one-cycle grant; credits are consumed on the grant edge
//   o_fc_hdr/dat_infinite[2:0]  per-class infinite-credit flags, indexed by type
//   o_fc_active                 tracker is in ACTIVE
//   o_starve                    a request has been blocked for STARVE_CYC cycles
//   o_type_err                  pulse for a request with the reserved type 3
module b4sq_credit_tracker #(
  parameter int HDR_W      = 8,
  parameter int DAT_W      = 12,
  parameter int STARVE_CYC = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_dl_up,
  input  logic             i_fc_init_valid,
  input  logic [1:0]       i_fc_init_type,
  input  logic [HDR_W-1:0] i_fc_init_hdr,
  input  logic [DAT_W-1:0] i_fc_init_dat,
  input  logic             i_fc_upd_valid,
  input  logic [1:0]       i_fc_upd_type,
  input  logic [HDR_W-1:0] i_fc_upd_hdr,
  input  logic [DAT_W-1:0] i_fc_upd_dat,
  input  logic             i_tx_req,
  input  logic [1:0]       i_tx_type,
  input  logic [DAT_W-1:0] i_tx_dat_cred,
  output logic             o_tx_gnt,
  output logic [2:0]       o_fc_hdr_infinite,
  output logic [2:0]       o_fc_dat_infinite,
  output logic             o_fc_active,
  output logic             o_starve,
  output logic             o_type_err
);

  typedef enum logic [1:0] {
    LINK_DOWN = 2'd0,
    FC_INIT   = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  localparam logic [HDR_W-1:0] HDR_ONE    = HDR_W'(1);
  localparam logic [HDR_W-1:0] HDR_HALF   = HDR_W'(1) << (HDR_W - 1);
  localparam logic [DAT_W-1:0] DAT_HALF   = DAT_W'(1) << (DAT_W - 1);
  localparam logic [15:0]      STARVE_MAX = 16'(STARVE_CYC);

  // Reset asserts immediately but releases only after two rising edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e           state_q, state_d;
  logic [HDR_W-1:0] lim_hdr_q [3];
  logic [HDR_W-1:0] lim_hdr_d [3];
  logic [DAT_W-1:0] lim_dat_q [3];
  logic [DAT_W-1:0] lim_dat_d [3];
  logic [HDR_W-1:0] cons_hdr_q [3];
  logic [HDR_W-1:0] cons_hdr_d [3];
  logic [DAT_W-1:0] cons_dat_q [3];
  logic [DAT_W-1:0] cons_dat_d [3];
  logic [2:0]       init_q, init_d;
  logic [2:0]       hdr_inf_q, hdr_inf_d;
  logic [2:0]       dat_inf_q, dat_inf_d;
  logic [15:0]      starve_q, starve_d;
  logic             gnt_q, gnt_d;
  logic             type_err_q, type_err_d;

  // Type 3 is clamped to class 0 for indexing; every use is gated by the *_ok flag.
  logic             tx_ok, init_ok, upd_ok;
  logic [1:0]       tx_cls, init_cls, upd_cls;
  logic [HDR_W-1:0] hdr_rem;
  logic [DAT_W-1:0] dat_rem;
  logic             hdr_av, dat_av;

  assign tx_ok    = (i_tx_type != 2'd3);
  assign init_ok  = (i_fc_init_type != 2'd3);
  assign upd_ok   = (i_fc_upd_type != 2'd3);
  assign tx_cls   = tx_ok   ? i_tx_type      : 2'd0;
  assign init_cls = init_ok ? i_fc_init_type : 2'd0;
  assign upd_cls  = upd_ok  ? i_fc_upd_type  : 2'd0;

  // Credits remaining after this TLP, modulo the counter width; a result in the
  // upper half of the range means the limit has been overrun.
  assign hdr_rem = lim_hdr_q[tx_cls] - (cons_hdr_q[tx_cls] + HDR_ONE);
  assign dat_rem = lim_dat_q[tx_cls] - (cons_dat_q[tx_cls] + i_tx_dat_cred);
  assign hdr_av  = hdr_inf_q[tx_cls] || (hdr_rem <= HDR_HALF);
  assign dat_av  = dat_inf_q[tx_cls] || (i_tx_dat_cred == '0) || (dat_rem <= DAT_HALF);

  always_comb begin
    state_d    = state_q;
    lim_hdr_d  = lim_hdr_q;
    lim_dat_d  = lim_dat_q;
    cons_hdr_d = cons_hdr_q;
    cons_dat_d = cons_dat_q;
    init_d     = init_q;
    hdr_inf_d  = hdr_inf_q;
    dat_inf_d  = dat_inf_q;
    starve_d   = starve_q;
    gnt_d      = 1'b0;
    type_err_d = 1'b0;
    if (!i_dl_up) begin
      state_d    = LINK_DOWN;
      lim_hdr_d  = '{default: '0};
      lim_dat_d  = '{default: '0};
      cons_hdr_d = '{default: '0};
      cons_dat_d = '{default: '0};
      init_d     = 3'b000;
      hdr_inf_d  = 3'b000;
      dat_inf_d  = 3'b000;
      starve_d   = '0;
    end else begin
      case (state_q)
        LINK_DOWN: state_d = FC_INIT;
        FC_INIT: begin
          if (init_q == 3'b111) state_d = ACTIVE;
          if (i_fc_init_valid && init_ok && !init_q[init_cls]) begin
            lim_hdr_d[init_cls] = i_fc_init_hdr;
            lim_dat_d[init_cls] = i_fc_init_dat;
            init_d[init_cls]    = 1'b1;
            hdr_inf_d[init_cls] = (i_fc_init_hdr == '0);
            dat_inf_d[init_cls] = (i_fc_init_dat == '0);
          end
        end
        ACTIVE: begin
          // Availability uses the pre-update limit even when an UpdateFC lands on the same edge.
          gnt_d      = i_tx_req && tx_ok && !gnt_q && hdr_av && dat_av;
          type_err_d = i_tx_req && !tx_ok && !type_err_q;
          if (gnt_d) begin
            if (!hdr_inf_q[tx_cls]) cons_hdr_d[tx_cls] = cons_hdr_q[tx_cls] + HDR_ONE;
            if (!dat_inf_q[tx_cls]) cons_dat_d[tx_cls] = cons_dat_q[tx_cls] + i_tx_dat_cred;
          end
          if (i_fc_upd_valid && upd_ok) begin
            if (!hdr_inf_q[upd_cls]) lim_hdr_d[upd_cls] = i_fc_upd_hdr;
            if (!dat_inf_q[upd_cls]) lim_dat_d[upd_cls] = i_fc_upd_dat;
          end
        end
        default: state_d = LINK_DOWN;
      endcase
      if (!i_tx_req || gnt_d) begin
        starve_d = '0;
      end else if ((state_q == ACTIVE) && !gnt_q && (starve_q != STARVE_MAX)) begin
        starve_d = starve_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LINK_DOWN;
      lim_hdr_q  <= '{default: '0};
      lim_dat_q  <= '{default: '0};
      cons_hdr_q <= '{default: '0};
      cons_dat_q <= '{default: '0};
      init_q     <= 3'b000;
      hdr_inf_q  <= 3'b000;
      dat_inf_q  <= 3'b000;
      starve_q   <= '0;
      gnt_q      <= 1'b0;
      type_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lim_hdr_q  <= lim_hdr_d;
      lim_dat_q  <= lim_dat_d;
      cons_hdr_q <= cons_hdr_d;
      cons_dat_q <= cons_dat_d;
      init_q     <= init_d;
      hdr_inf_q  <= hdr_inf_d;
      dat_inf_q  <= dat_inf_d;
      starve_q   <= starve_d;
      gnt_q      <= gnt_d;
      type_err_q <= type_err_d;
    end
  end

  assign o_tx_gnt          = gnt_q;
  assign o_type_err        = type_err_q;
  assign o_fc_hdr_infinite = hdr_inf_q;
  assign o_fc_dat_infinite = dat_inf_q;
  assign o_fc_active       = (state_q == ACTIVE);
  assign o_starve          = (starve_q == STARVE_MAX);

endmodule

// File: tb/tb_b4sq_credit_tracker.sv
// tb/tb_b4sq_credit_tracker.sv - scoreboard bench for b4sq_credit_tracker
`timescale 1ns/1ps
module tb_b4sq_credit_tracker;
  localparam int SC = 16;
  localparam int HM = 256;
  localparam int DM = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, dl_up;
  logic        iv, uv, req;
  logic [1:0]  it, ut, tt;
  logic [7:0]  ih, uh;
  logic [11:0] id, ud, tc;
  logic        o_tx_gnt, o_fc_active, o_starve, o_type_err;
  logic [2:0]  o_fc_hdr_infinite, o_fc_dat_infinite;

  b4sq_credit_tracker #(.HDR_W(8), .DAT_W(12), .STARVE_CYC(SC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dl_up(dl_up),
    .i_fc_init_valid(iv), .i_fc_init_type(it), .i_fc_init_hdr(ih), .i_fc_init_dat(id),
    .i_fc_upd_valid(uv), .i_fc_upd_type(ut), .i_fc_upd_hdr(uh), .i_fc_upd_dat(ud),
    .i_tx_req(req), .i_tx_type(tt), .i_tx_dat_cred(tc),
    .o_tx_gnt(o_tx_gnt), .o_fc_hdr_infinite(o_fc_hdr_infinite),
    .o_fc_dat_infinite(o_fc_dat_infinite), .o_fc_active(o_fc_active),
    .o_starve(o_starve), .o_type_err(o_type_err)
  );

  typedef struct packed {
    logic       gnt, terr, starve, active;
    logic [2:0] hinf, dinf;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0, n_fail = 0;
  int   gnt_seen = 0, terr_seen = 0;

  // Reference model: link phase 0=down 1=init 2=active, credits as plain integers.
  int   m_phase, m_starve;
  int   m_lh[3], m_ld[3], m_ch[3], m_cd[3];
  bit   m_init[3], m_hi[3], m_di[3];
  bit   m_gnt, m_terr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wrapm(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  task automatic model_clear();
    m_phase = 0; m_starve = 0; m_gnt = 0; m_terr = 0;
    for (int k = 0; k < 3; k++) begin
      m_lh[k] = 0; m_ld[k] = 0; m_ch[k] = 0; m_cd[k] = 0;
      m_init[k] = 0; m_hi[k] = 0; m_di[k] = 0;
    end
  endtask

  task automatic model_step();
    int  t, c, u;
    bit  g, te, hok, dok, all_init;
    if (!dl_up) begin
      model_clear();
      return;
    end
    t = int'(tt); c = int'(tc); u = int'(ut);
    g = 0; te = 0;
    if (m_phase == 2 && req) begin
      if (t == 3) te = !m_terr;
      else begin
        hok = m_hi[t] || (wrapm(m_lh[t] - m_ch[t] - 1, HM) <= HM / 2);
        dok = m_di[t] || (c == 0) || (wrapm(m_ld[t] - m_cd[t] - c, DM) <= DM / 2);
        g   = !m_gnt && hok && dok;
      end
    end
    if (!req || g) m_starve = 0;
    else if (m_phase == 2 && !m_gnt && m_starve < SC) m_starve++;
    if (g) begin
      if (!m_hi[t]) m_ch[t] = (m_ch[t] + 1) % HM;
      if (!m_di[t]) m_cd[t] = (m_cd[t] + c) % DM;
    end
    if (m_phase == 2 && uv && u != 3) begin
      if (!m_hi[u]) m_lh[u] = int'(uh);
      if (!m_di[u]) m_ld[u] = int'(ud);
    end
    if (m_phase == 1) begin
      all_init = m_init[0] && m_init[1] && m_init[2];
      if (iv && it != 2'd3 && !m_init[it]) begin
        m_lh[it] = int'(ih); m_ld[it] = int'(id);
        m_init[it] = 1; m_hi[it] = (ih == 0); m_di[it] = (id == 0);
      end
      if (all_init) m_phase = 2;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end
    m_gnt = g; m_terr = te;
  endtask

  task automatic step();
    exp_t e;
    model_step();
    e.gnt = m_gnt; e.terr = m_terr; e.starve = (m_starve == SC); e.active = (m_phase == 2);
    e.hinf = {m_hi[2], m_hi[1], m_hi[0]};
    e.dinf = {m_di[2], m_di[1], m_di[0]};
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("gnt",    32'(o_tx_gnt),          32'(mon_e.gnt));
      chk("terr",   32'(o_type_err),        32'(mon_e.terr));
      chk("starve", 32'(o_starve),          32'(mon_e.starve));
      chk("active", 32'(o_fc_active),       32'(mon_e.active));
      chk("hinf",   32'(o_fc_hdr_infinite), 32'(mon_e.hinf));
      chk("dinf",   32'(o_fc_dat_infinite), 32'(mon_e.dinf));
    end
    if (o_tx_gnt)   gnt_seen++;
    if (o_type_err) terr_seen++;
  end

  task automatic send_init(input logic [1:0] t, input logic [7:0] h, input logic [11:0] d);
    iv = 1'b1; it = t; ih = h; id = d;
    step();
    iv = 1'b0;
  endtask

  task automatic send_upd(input logic [1:0] t, input logic [7:0] h, input logic [11:0] d);
    uv = 1'b1; ut = t; uh = h; ud = d;
    step();
    uv = 1'b0;
  endtask

  // Holds a request, dropping it in every cycle that shows a grant.
  task automatic run_req(input logic [1:0] t, input logic [11:0] c, input int n);
    for (int k = 0; k < n; k++) begin
      tt = t; tc = c; req = !m_gnt;
      step();
    end
    req = 1'b0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, t0;
    rst_n = 1'b0; dl_up = 1'b1; req = 1'b1; tt = 2'd0; tc = 12'd0;
    iv = 1'b0; it = 2'd0; ih = 8'd0; id = 12'd0;
    uv = 1'b0; ut = 2'd0; uh = 8'd0; ud = 12'd0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt",    32'(o_tx_gnt),          0);
    chk("rst_active", 32'(o_fc_active),       0);
    chk("rst_starve", 32'(o_starve),          0);
    chk("rst_terr",   32'(o_type_err),        0);
    chk("rst_hinf",   32'(o_fc_hdr_infinite), 0);
    chk("rst_dinf",   32'(o_fc_dat_infinite), 0);
    dl_up = 1'b0; req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (4) step();

    dl_up = 1'b1;
    step();
    send_init(2'd0, 8'd4, 12'd16);
    send_init(2'd1, 8'd2, 12'd0);
    send_init(2'd2, 8'd0, 12'd0);
    step();
    chk("init_active", 32'(o_fc_active),       1);
    chk("init_hinf",   32'(o_fc_hdr_infinite), 32'h4);
    chk("init_dinf",   32'(o_fc_dat_infinite), 32'h6);

    g0 = gnt_seen;
    run_req(2'd0, 12'd4, 12);
    chk("p_grants", 32'(gnt_seen - g0), 4);

    g0 = gnt_seen;
    req = 1'b1; tt = 2'd0; tc = 12'd4;
    send_upd(2'd0, 8'd5, 12'd20);
    step();
    chk("upd_gnt", 32'(o_tx_gnt), 1);
    run_req(2'd0, 12'd4, 4);
    chk("upd_grants", 32'(gnt_seen - g0), 1);

    req = 1'b1; tt = 2'd0; tc = 12'd4;
    repeat (20) step();
    chk("starve_set", 32'(o_starve), 1);
    send_upd(2'd0, 8'd6, 12'd24);
    step();
    chk("starve_gnt", 32'(o_tx_gnt), 1);
    chk("starve_clr", 32'(o_starve), 0);
    req = 1'b0;
    step();

    g0 = gnt_seen; t0 = terr_seen;
    req = 1'b1; tt = 2'd3; tc = 12'd0;
    repeat (6) step();
    req = 1'b0;
    step();
    chk("t3_pulses", 32'(terr_seen - t0), 3);
    chk("t3_grants", 32'(gnt_seen - g0), 0);
    g0 = gnt_seen;
    run_req(2'd0, 12'd0, 6);
    chk("t3_no_cons", 32'(gnt_seen - g0), 0);

    send_upd(2'd0, 8'd106, 12'd24);
    g0 = gnt_seen; run_req(2'd0, 12'd0, 210);
    chk("wrap_a", 32'(gnt_seen - g0), 100);
    send_upd(2'd0, 8'd206, 12'd24);
    g0 = gnt_seen; run_req(2'd0, 12'd0, 210);
    chk("wrap_b", 32'(gnt_seen - g0), 100);
    send_upd(2'd0, 8'd255, 12'd24);
    g0 = gnt_seen; run_req(2'd0, 12'd0, 110);
    chk("wrap_c", 32'(gnt_seen - g0), 49);
    send_upd(2'd0, 8'h02, 12'd24);
    g0 = gnt_seen; run_req(2'd0, 12'd0, 12);
    chk("wrap_hdr", 32'(gnt_seen - g0), 3);
    send_upd(2'd0, 8'h03, 12'h817);
    g0 = gnt_seen; run_req(2'd0, 12'h800, 8);
    chk("wrap_dat_block", 32'(gnt_seen - g0), 0);
    g0 = gnt_seen; run_req(2'd0, 12'h7FF, 4);
    chk("wrap_dat_fit", 32'(gnt_seen - g0), 1);

    req = 1'b1; tt = 2'd0; tc = 12'h100;
    repeat (3) step();
    dl_up = 1'b0;
    step();
    chk("down_active", 32'(o_fc_active),       0);
    chk("down_gnt",    32'(o_tx_gnt),          0);
    chk("down_hinf",   32'(o_fc_hdr_infinite), 0);
    chk("down_dinf",   32'(o_fc_dat_infinite), 0);
    dl_up = 1'b1;
    g0 = gnt_seen;
    run_req(2'd0, 12'd0, 10);
    chk("down_no_gnt", 32'(gnt_seen - g0), 0);
    send_init(2'd0, 8'd50, 12'd300);
    send_init(2'd1, 8'd0, 12'd100);
    send_init(2'd2, 8'd20, 12'd0);
    step();
    chk("reinit_active", 32'(o_fc_active), 1);

    for (int i = 0; i < 3000; i++) begin
      if (!dl_up) dl_up = ($urandom_range(0, 2) == 0);
      else        dl_up = ($urandom_range(0, 599) != 0);
      iv = ($urandom_range(0, 3) == 0);
      it = 2'($urandom_range(0, 3));
      ih = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      id = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom);
      uv = ($urandom_range(0, 3) == 0);
      ut = 2'($urandom_range(0, 3));
      uh = 8'($urandom);
      ud = 12'($urandom);
      if (m_gnt) req = 1'b0;
      else if (req) begin
        if ($urandom_range(0, 15) == 0) req = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        req = 1'b1;
        tt  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        tc  = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(0, 300));
      end
      step();
    end
    iv = 1'b0; uv = 1'b0; req = 1'b0;
    repeat (3) step();
    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
